// File: rtl/seq_alu.sv
// Sequential ALU with valid/ready handshakes on both sides. Most operations
// finish in one cycle. MULT (shift-add) and DIV (restoring) iterate once per
// cycle for N cycles. Result and flags are held until the consumer takes them.
module seq_alu #(
    parameter int N  = 16,
    parameter int CW = $clog2(N + 1)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [3:0]     op,
    input  logic [N-1:0]   a,
    input  logic [N-1:0]   b,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [2*N-1:0] result,
    output logic           carry,
    output logic           borrow,
    output logic           div_zero,
    output logic           illegal_op,
    output logic           busy
);

    localparam int W = 2 * N;

    localparam logic [3:0] OpAdd  = 4'd0;
    localparam logic [3:0] OpSub  = 4'd1;
    localparam logic [3:0] OpMul  = 4'd2;
    localparam logic [3:0] OpDiv  = 4'd3;
    localparam logic [3:0] OpSll  = 4'd4;
    localparam logic [3:0] OpSrl  = 4'd5;
    localparam logic [3:0] OpAnd  = 4'd6;
    localparam logic [3:0] OpOr   = 4'd7;
    localparam logic [3:0] OpXor  = 4'd8;
    localparam logic [3:0] OpNot  = 4'd9;
    localparam logic [3:0] OpNand = 4'd10;
    localparam logic [3:0] OpNor  = 4'd11;

    typedef enum logic [1:0] {StIdle, StBusy, StDone} state_t;

    state_t         state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic           is_div_q, is_div_d;
    // Iteration datapath. MULT: acc = partial product, x = shifted multiplicand,
    // y = multiplier shifting right. DIV: acc[N:0] = partial remainder,
    // x[N-1:0] = divisor, y = dividend shifting out / quotient shifting in.
    logic [W-1:0]   acc_q, acc_d;
    logic [W-1:0]   x_q, x_d;
    logic [N-1:0]   y_q, y_d;
    logic [W-1:0]   result_q, result_d;
    logic           carry_q, carry_d;
    logic           borrow_q, borrow_d;
    logic           div_zero_q, div_zero_d;
    logic           illegal_q, illegal_d;

    // Single-cycle results
    logic [W-1:0]   sc_result;
    logic           sc_carry, sc_borrow, sc_div_zero, sc_illegal, sc_iter;
    logic [N:0]     sum;
    logic [W-1:0]   a_ext;

    // One iteration step of the multiplier / divider
    logic [W-1:0]   mul_acc_nx;
    logic [N:0]     divisor, rem_shift, rem_nx;
    logic [N-1:0]   quo_nx;
    logic           fits;

    assign sum   = {1'b0, a} + {1'b0, b};
    assign a_ext = {{N{1'b0}}, a};

    // Decode the opcode into a one-cycle result or a request to iterate
    always_comb begin
        sc_result   = '0;
        sc_carry    = 1'b0;
        sc_borrow   = 1'b0;
        sc_div_zero = 1'b0;
        sc_illegal  = 1'b0;
        sc_iter     = 1'b0;
        case (op)
            OpAdd: begin
                sc_result = {{(N-1){1'b0}}, sum};
                sc_carry  = sum[N];
            end
            OpSub: begin
                sc_result = {{N{1'b0}}, a - b};
                sc_borrow = (a < b);
            end
            OpMul: sc_iter = 1'b1;
            OpDiv: begin
                if (b == '0) begin
                    sc_result   = '1;
                    sc_div_zero = 1'b1;
                end else begin
                    sc_iter = 1'b1;
                end
            end
            // Logical shifts by >= operand width already yield zero
            OpSll:  sc_result = a_ext << b;
            OpSrl:  sc_result = a_ext >> b;
            OpAnd:  sc_result = {{N{1'b0}}, a & b};
            OpOr:   sc_result = {{N{1'b0}}, a | b};
            OpXor:  sc_result = {{N{1'b0}}, a ^ b};
            OpNot:  sc_result = {{N{1'b0}}, ~a};
            OpNand: sc_result = {{N{1'b0}}, ~(a & b)};
            OpNor:  sc_result = {{N{1'b0}}, ~(a | b)};
            default: sc_illegal = 1'b1;
        endcase
    end

    // Next value of the multiplier accumulator and the restoring divider
    always_comb begin
        mul_acc_nx = y_q[0] ? (acc_q + x_q) : acc_q;
        divisor    = {1'b0, x_q[N-1:0]};
        rem_shift  = {acc_q[N-1:0], y_q[N-1]};
        fits       = (rem_shift >= divisor);
        rem_nx     = fits ? (rem_shift - divisor) : rem_shift;
        quo_nx     = {y_q[N-2:0], fits};
    end

    // Control FSM next-state plus datapath / result register updates
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        is_div_d   = is_div_q;
        acc_d      = acc_q;
        x_d        = x_q;
        y_d        = y_q;
        result_d   = result_q;
        carry_d    = carry_q;
        borrow_d   = borrow_q;
        div_zero_d = div_zero_q;
        illegal_d  = illegal_q;
        case (state_q)
            StIdle: begin
                if (in_valid) begin
                    if (sc_iter) begin
                        state_d  = StBusy;
                        cnt_d    = CW'(N);
                        is_div_d = (op == OpDiv);
                        acc_d    = '0;
                        if (op == OpDiv) begin
                            x_d = {{N{1'b0}}, b};
                            y_d = a;
                        end else begin
                            x_d = {{N{1'b0}}, a};
                            y_d = b;
                        end
                    end else begin
                        state_d    = StDone;
                        result_d   = sc_result;
                        carry_d    = sc_carry;
                        borrow_d   = sc_borrow;
                        div_zero_d = sc_div_zero;
                        illegal_d  = sc_illegal;
                    end
                end
            end
            StBusy: begin
                cnt_d = cnt_q - CW'(1);
                if (is_div_q) begin
                    acc_d = {{(N-1){1'b0}}, rem_nx};
                    y_d   = quo_nx;
                end else begin
                    acc_d = mul_acc_nx;
                    x_d   = x_q << 1;
                    y_d   = y_q >> 1;
                end
                // Last iteration: load the result directly from the step logic
                if (cnt_q == CW'(1)) begin
                    state_d    = StDone;
                    result_d   = is_div_q ? {rem_nx[N-1:0], quo_nx} : mul_acc_nx;
                    carry_d    = 1'b0;
                    borrow_d   = 1'b0;
                    div_zero_d = 1'b0;
                    illegal_d  = 1'b0;
                end
            end
            StDone: begin
                if (out_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State and datapath registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            is_div_q   <= 1'b0;
            acc_q      <= '0;
            x_q        <= '0;
            y_q        <= '0;
            result_q   <= '0;
            carry_q    <= 1'b0;
            borrow_q   <= 1'b0;
            div_zero_q <= 1'b0;
            illegal_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            is_div_q   <= is_div_d;
            acc_q      <= acc_d;
            x_q        <= x_d;
            y_q        <= y_d;
            result_q   <= result_d;
            carry_q    <= carry_d;
            borrow_q   <= borrow_d;
            div_zero_q <= div_zero_d;
            illegal_q  <= illegal_d;
        end
    end

    assign in_ready   = (state_q == StIdle);
    assign out_valid  = (state_q == StDone);
    assign busy       = (state_q == StBusy);
    assign result     = result_q;
    assign carry      = carry_q;
    assign borrow     = borrow_q;
    assign div_zero   = div_zero_q;
    assign illegal_op = illegal_q;

endmodule

// File: doc/seq_alu.md
Name: seq_alu

Overview:
- Parametrised, handshaked successor to the combinational 16-bit operator set: ADD, SUB, MULT, DIV, shifts and bitwise logic, with a width parameter and registered outputs.
- MULT is a shift-add multiplier and DIV a restoring divider; both are iterative and take N cycles each.
- Adds status flags and quotient/remainder output.
- Sits between the operand/opcode source and the result consumer, using valid/ready on both sides.

Parameters:
- N, 16, operand width in bits (N >= 2); result width is 2N.
- CW, $clog2(N+1), width of the internal iteration counter.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  op/a/b are valid.
- in_ready  output  1  block can accept an operation.
- op  input  4  opcode: 0 ADD, 1 SUB, 2 MULT, 3 DIV, 4 SLL, 5 SRL, 6 AND, 7 OR, 8 XOR, 9 NOT, 10 NAND, 11 NOR, 12-15 illegal.
- a  input  N  operand A.
- b  input  N  operand B, or the shift amount.
- out_valid  output  1  result and flags are valid.
- out_ready  input  1  consumer accepts the result.
- result  output  2N  registered result.
- carry  output  1  ADD carry-out.
- borrow  output  1  SUB borrow (a < b).
- div_zero  output  1  DIV with b == 0.
- illegal_op  output  1  opcode 12-15 was accepted.
- busy  output  1  MULT/DIV iteration in progress.

Behaviour:
- Reset:
  - state = IDLE.
  - in_ready = 1; out_valid, busy, result and all flags = 0.
  - A reset asserted mid-operation aborts the operation with no output.
- State machine has three states: IDLE, BUSY, DONE.
- IDLE:
  - in_ready = 1.
  - Accept on the edge E where in_valid && in_ready; op, a and b are captured.
- Single-cycle ops (ADD, SUB, shifts, logic, illegal, DIV by zero):
  - result and flags are registered at edge E.
  - Go to DONE; out_valid = 1 from edge E.
- MULT or DIV with b != 0:
  - Go to BUSY with counter = N; busy = 1; in_ready = 0.
  - One iteration per cycle; the counter decrements each cycle.
  - After the final iteration, result is loaded and state goes to DONE; out_valid = 1 from edge E+N.
- DONE:
  - out_valid = 1 and in_ready = 0.
  - result and flags are held stable until out_valid && out_ready.
  - On that edge go to IDLE, out_valid = 0; result and flags are not cleared.
  - No new accept happens in the same cycle; minimum issue interval is 2 cycles.
- Flags:
  - All flags are updated on every result load.
  - Any flag that does not apply to the op is 0.
- Arithmetic rules (zero-extended unless stated):
  - ADD: result = a + b, N+1 bits, zero-extended; carry = bit N of the sum.
  - SUB: result[N-1:0] = (a - b) mod 2^N, upper bits 0; borrow = (a < b).
  - MULT: result = a * b, full 2N-bit unsigned product.
  - DIV: result = {remainder[N-1:0], quotient[N-1:0]}, unsigned.
  - DIV with b == 0: result = all ones, div_zero = 1, single-cycle.
  - SLL: result = zero-extend(a) << b. A shift of b >= 2N gives 0.
  - SRL: result = zero-extend(a) >> b. A shift of b >= N gives 0.
  - AND, OR, XOR, NAND, NOR: bitwise on N bits, zero-extended to 2N.
  - NOT: bitwise inversion of a, zero-extended to 2N; b is ignored.
  - Illegal opcode: result = 0, illegal_op = 1.
- Input handling:
  - Inputs are ignored whenever in_ready = 0.
  - in_valid asserted in BUSY or DONE is not accepted; the source must hold it until in_ready.
- Ports are driven only from registers and state; there are no combinational paths from in_valid or out_ready to outputs.

Test Plan:
- Reset: hold rst 2 cycles -> in_ready = 1; out_valid = 0; result = 0; all flags = 0.
- ADD, N = 16: a = 50000, b = 50000, out_ready = 1 -> out_valid the cycle after accept; result = 0x000186A0; carry = 1.
- MULT: a = 0xFFFF, b = 0xFFFF -> busy = 1 for 16 cycles; in_ready = 0 meanwhile; out_valid at accept+16; result = 0xFFFE0001.
- DIV:
  - a = 100, b = 7 -> result = 0x0002000E at accept+16.
  - a = 5, b = 0 -> single-cycle; result = 0xFFFFFFFF; div_zero = 1.
- Backpressure:
  - Accept SUB a = 3, b = 5.
  - Keep out_ready = 0 for 5 cycles -> result = 0x0000FFFE and borrow = 1 held stable; in_ready = 0.
  - Raise out_ready -> IDLE next edge.
- Shifts and illegal:
  - SLL a = 1, b = 20 -> 0x00100000.
  - SLL b = 40 -> 0.
  - SRL a = 0x8000, b = 15 -> 1.
  - op = 13 -> result = 0, illegal_op = 1.
- Reset mid-MULT: assert rst at accept+5 -> next edge IDLE; out_valid never rises for that op; the next ADD completes correctly.
